// File: rtl/cfg_spi_sched.sv
// Configuration command scheduler: queues parser commands in a small FIFO and serialises
// each one onto the shared sclk/sdata/le bus, one frame at a time in arrival order.
module cfg_spi_sched #(
  parameter logic [15:0] CLK_DIV   = 16'd5,
  parameter int unsigned FIFO_AW   = 2,
  parameter logic [7:0]  LE_CYCLES = 8'd10
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cmd_vld,
  input  logic [1:0]  cmd_addr,
  input  logic [5:0]  cmd_mod,
  input  logic [23:0] cmd_data,
  output logic        cmd_full,
  output logic        ovf_err,
  output logic        sel_err,
  output logic        spi_sclk,
  output logic        spi_sdata,
  output logic [5:0]  spi_le,
  output logic        busy,
  output logic        done
);

  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DepthC = (FIFO_AW + 1)'(Depth);

  typedef enum logic [2:0] {StIdle, StLoad, StShift, StLatch, StGap} state_e;

  logic [31:0]        mem_q [Depth];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               ovf_q, sel_q, sel_d;
  logic               push, pop;
  logic [31:0]        head;

  state_e      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [7:0]  le_q, le_d;
  logic [4:0]  bit_q, bit_d;
  logic        phase_q, phase_d;
  logic        le_on_q, le_on_d;
  logic [25:0] word_q, word_d;
  logic [5:0]  mod_q, mod_d;

  assign cmd_full = (cnt_q == DepthC);
  // Full is judged on the registered count, so a same-cycle pop never rescues a push.
  assign push     = cmd_vld && !cmd_full;
  assign pop      = (state_q == StLoad);
  assign head     = mem_q[rptr_q];

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wptr_q] <= {cmd_addr, cmd_mod, cmd_data};
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
      ovf_q <= ovf_q | (cmd_vld & cmd_full);
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    le_d    = le_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    le_on_d = le_on_q;
    word_d  = word_q;
    mod_d   = mod_q;
    sel_d   = sel_q;
    unique case (state_q)
      StIdle: begin
        if (cnt_q != '0) state_d = StLoad;
      end
      StLoad: begin
        if (head[29:24] == 6'd0) begin
          sel_d   = 1'b1;
          state_d = StIdle;
        end else begin
          word_d  = {head[23:0], head[31:30]};
          mod_d   = head[29:24];
          bit_d   = 5'd25;
          div_d   = '0;
          phase_d = 1'b0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (div_q == CLK_DIV - 16'd1) begin
          div_d = '0;
          if (phase_q) begin
            phase_d = 1'b0;
            if (bit_q == 5'd0) begin
              le_on_d = 1'b0;
              state_d = StLatch;
            end else begin
              bit_d = bit_q - 5'd1;
            end
          end else begin
            phase_d = 1'b1;
          end
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      StLatch: begin
        // Setup phase with le low, then le held for LE_CYCLES.
        if (!le_on_q) begin
          if (div_q == CLK_DIV - 16'd1) begin
            div_d   = '0;
            le_d    = '0;
            le_on_d = 1'b1;
          end else begin
            div_d = div_q + 16'd1;
          end
        end else if (le_q == LE_CYCLES - 8'd1) begin
          div_d   = '0;
          state_d = StGap;
        end else begin
          le_d = le_q + 8'd1;
        end
      end
      StGap: begin
        if (div_q == CLK_DIV - 16'd1) begin
          div_d   = '0;
          state_d = StIdle;
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      le_q    <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      le_on_q <= 1'b0;
      word_q  <= '0;
      mod_q   <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      le_q    <= le_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      le_on_q <= le_on_d;
      word_q  <= word_d;
      mod_q   <= mod_d;
      sel_q   <= sel_d;
    end
  end

  assign ovf_err   = ovf_q;
  assign sel_err   = sel_q;
  assign busy      = (state_q != StIdle);
  assign spi_sclk  = (state_q == StShift) && phase_q;
  assign spi_sdata = (state_q == StShift) && word_q[bit_q];
  assign spi_le    = ((state_q == StLatch) && le_on_q) ? mod_q : 6'd0;
  assign done      = (state_q == StGap) && (div_q == CLK_DIV - 16'd1);

endmodule

// File: tb/tb_cfg_spi_sched.sv
// Bench for cfg_spi_sched: two instances (CLK_DIV 5 and 1) checked against a cycle-budget
// model of FIFO occupancy and frame timing, plus a bus monitor that decodes each frame.
module tb_cfg_spi_sched;
  localparam int LeCyc = 10;
  localparam int Depth = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        vld [2];
  logic [1:0]  addr [2];
  logic [5:0]  mod [2];
  logic [23:0] data [2];
  logic        full [2], ovf [2], sel [2], sclk [2], sdata [2], busy [2], done [2];
  logic [5:0]  le [2];

  cfg_spi_sched #(.CLK_DIV(16'd5), .FIFO_AW(2), .LE_CYCLES(8'd10)) u_dut5 (
    .sys_clk(clk), .sys_rst(rst[0]), .cmd_vld(vld[0]), .cmd_addr(addr[0]), .cmd_mod(mod[0]),
    .cmd_data(data[0]), .cmd_full(full[0]), .ovf_err(ovf[0]), .sel_err(sel[0]),
    .spi_sclk(sclk[0]), .spi_sdata(sdata[0]), .spi_le(le[0]), .busy(busy[0]), .done(done[0])
  );

  cfg_spi_sched #(.CLK_DIV(16'd1), .FIFO_AW(2), .LE_CYCLES(8'd10)) u_dut1 (
    .sys_clk(clk), .sys_rst(rst[1]), .cmd_vld(vld[1]), .cmd_addr(addr[1]), .cmd_mod(mod[1]),
    .cmd_data(data[1]), .cmd_full(full[1]), .ovf_err(ovf[1]), .sel_err(sel[1]),
    .spi_sclk(sclk[1]), .spi_sdata(sdata[1]), .spi_le(le[1]), .busy(busy[1]), .done(done[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queued commands, expected frames, and when the block is next idle.
  logic [31:0] fq [2][$];
  logic [31:0] exp_q [2][$];
  int          e_now [2], idle_from [2], exp_flush [2], exp_rd [2], frames [2];
  bit          m_load [2], m_ovf [2], m_sel [2], chk_en [2];

  bit          prev_sclk [2];
  logic [25:0] bits [2];
  logic [5:0]  le_val [2];
  int          nbits [2], hi_run [2], lo_run [2], le_len [2], gap_len [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int dv(input int i);
    return (i == 0) ? 5 : 1;
  endfunction

  // Applies the rules for the clock edge that follows, using the inputs now on the pins.
  task automatic model_step(input int i);
    logic [31:0] h;
    bit was_full, cur_idle, nload;
    e_now[i]++;
    if (rst[i]) begin
      fq[i].delete();
      m_load[i]    = 1'b0;
      idle_from[i] = e_now[i];
      m_ovf[i]     = 1'b0;
      m_sel[i]     = 1'b0;
      exp_flush[i] = exp_q[i].size();
      chk_en[i]    = 1'b1;
      return;
    end
    was_full = (fq[i].size() == Depth);
    cur_idle = !m_load[i] && (e_now[i] - 1 >= idle_from[i]);
    nload    = 1'b0;
    if (m_load[i]) begin
      h = fq[i].pop_front();
      if (h[29:24] == 6'd0) begin
        m_sel[i]     = 1'b1;
        idle_from[i] = e_now[i];
      end else begin
        exp_q[i].push_back(h);
        idle_from[i] = e_now[i] + 54 * dv(i) + LeCyc;
      end
    end else if (cur_idle && fq[i].size() != 0) begin
      nload = 1'b1;
    end
    if (vld[i]) begin
      if (!was_full) fq[i].push_back({addr[i], mod[i], data[i]});
      else m_ovf[i] = 1'b1;
    end
    m_load[i] = nload;
  endtask

  task automatic clr_frame(input int i);
    nbits[i]   = 0;
    bits[i]    = '0;
    hi_run[i]  = 0;
    lo_run[i]  = 0;
    le_len[i]  = 0;
    gap_len[i] = 0;
    le_val[i]  = '0;
  endtask

  task automatic monitor(input int i);
    bit mb;
    logic [31:0] e;
    if (!chk_en[i]) return;
    mb = m_load[i] || (e_now[i] < idle_from[i]);
    check($sformatf("busy%0d", i), {31'd0, busy[i]}, {31'd0, mb});
    check($sformatf("full%0d", i), {31'd0, full[i]}, {31'd0, fq[i].size() == Depth});
    check($sformatf("ovf%0d", i), {31'd0, ovf[i]}, {31'd0, m_ovf[i]});
    check($sformatf("sel%0d", i), {31'd0, sel[i]}, {31'd0, m_sel[i]});
    if (!mb) check($sformatf("idle_bus%0d", i), {23'd0, sclk[i], sdata[i], le[i], done[i]}, 0);
    if (rst[i]) begin
      clr_frame(i);
      exp_rd[i]    = exp_flush[i];
      prev_sclk[i] = 1'b0;
      return;
    end
    if (sclk[i] && !prev_sclk[i]) begin
      if (nbits[i] > 0) check($sformatf("sclk_low%0d", i), lo_run[i], dv(i));
      bits[i] = {bits[i][24:0], sdata[i]};
      nbits[i]++;
      hi_run[i] = 1;
    end else if (sclk[i]) begin
      hi_run[i]++;
    end
    if (!sclk[i] && prev_sclk[i]) begin
      check($sformatf("sclk_high%0d", i), hi_run[i], dv(i));
      lo_run[i] = 1;
    end else if (!sclk[i]) begin
      lo_run[i]++;
    end
    prev_sclk[i] = sclk[i];
    if (le[i] != 6'd0) begin
      le_val[i] = (le_len[i] == 0) ? le[i] : (le_val[i] | le[i]);
      le_len[i]++;
    end else if (le_len[i] > 0) begin
      gap_len[i]++;
    end
    if (done[i]) begin
      if (exp_rd[i] < exp_q[i].size()) begin
        e = exp_q[i][exp_rd[i]];
        exp_rd[i]++;
        check($sformatf("frame_bits%0d", i), nbits[i], 26);
        check($sformatf("frame_word%0d", i), {6'd0, bits[i]}, {6'd0, e[23:0], e[31:30]});
        check($sformatf("frame_le%0d", i), {26'd0, le_val[i]}, {26'd0, e[29:24]});
        check($sformatf("frame_le_len%0d", i), le_len[i], LeCyc);
        check($sformatf("frame_gap%0d", i), gap_len[i], dv(i));
      end else begin
        check($sformatf("done_unexpected%0d", i), {31'd0, done[i]}, 0);
      end
      frames[i]++;
      clr_frame(i);
    end
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(negedge clk);
    monitor(0);
    monitor(1);
  endtask

  task automatic push(input int i, input logic [1:0] a, input logic [5:0] m,
                      input logic [23:0] d);
    vld[i]  = 1'b1;
    addr[i] = a;
    mod[i]  = m;
    data[i] = d;
    tick();
    vld[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int budget);
    for (int n = 0; n < budget && (busy[i] || m_load[i] || fq[i].size() != 0); n++) tick();
    check($sformatf("idle_reached%0d", i), {31'd0, busy[i]}, 0);
  endtask

  initial begin
    int f_before;
    int burst [2];
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; vld[i] = 1'b0; addr[i] = '0; mod[i] = '0; data[i] = '0;
      e_now[i] = 0; idle_from[i] = 0; exp_flush[i] = 0; exp_rd[i] = 0; frames[i] = 0;
      m_load[i] = 0; m_ovf[i] = 0; m_sel[i] = 0; chk_en[i] = 0; prev_sclk[i] = 0;
      burst[i] = 0;
      clr_frame(i);
    end
    repeat (3) tick();
    check("reset_outputs0", {18'd0, full[0], ovf[0], sel[0], sclk[0], sdata[0], le[0], busy[0],
                             done[0]}, 0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    tick();

    push(0, 2'd0, 6'h01, 24'hABCDEF);
    wait_idle(0, 3000);
    check("single_frames", frames[0], 1);

    push(0, 2'd1, 6'h04, 24'h123456);
    push(0, 2'd2, 6'h08, 24'h654321);
    push(0, 2'd3, 6'h10, 24'hC0FFEE);
    wait_idle(0, 3000);
    check("b2b_frames", frames[0], 4);
    check("b2b_no_ovf", {31'd0, ovf[0]}, 0);

    push(0, 2'd1, 6'h20, 24'h111111);
    repeat (10) tick();
    for (int k = 0; k < 5; k++) begin
      push(0, 2'(k), 6'h01 << (k % 6), 24'h200000 + 24'(k));
      if (k == 3) check("full_after_4th", {31'd0, full[0]}, 1);
    end
    check("ovf_after_5th", {31'd0, ovf[0]}, 1);
    wait_idle(0, 6000);
    check("ovf_frames", frames[0], 9);

    push(0, 2'd2, 6'h00, 24'hDEAD00);
    push(0, 2'd1, 6'h02, 24'h00BEEF);
    wait_idle(0, 3000);
    check("zero_sel_err", {31'd0, sel[0]}, 1);
    check("zero_frames", frames[0], 10);

    push(0, 2'd0, 6'h01, 24'hA5A5A5);
    push(0, 2'd1, 6'h02, 24'h5A5A5A);
    push(0, 2'd2, 6'h04, 24'h0F0F0F);
    for (int n = 0; n < 2000 && nbits[0] < 13; n++) tick();
    check("reach_bit12", nbits[0], 13);
    f_before = frames[0];
    rst[0] = 1'b1;
    tick();
    check("rst_outputs", {18'd0, full[0], ovf[0], sel[0], sclk[0], sdata[0], le[0], busy[0],
                          done[0]}, 0);
    rst[0] = 1'b0;
    repeat (1500) tick();
    check("rst_no_frames", frames[0], f_before);

    push(1, 2'd3, 6'h3F, 24'h000001);
    wait_idle(1, 500);
    check("div1_frames", frames[1], 1);

    for (int c = 0; c < 5000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (burst[i] == 0 && $urandom_range(0, 399) == 0) burst[i] = $urandom_range(2, 7);
        vld[i]  = (burst[i] > 0) || ($urandom_range(0, 99) < ((i == 0) ? 2 : 6));
        addr[i] = 2'($urandom_range(0, 3));
        mod[i]  = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        data[i] = 24'($urandom);
        if (burst[i] > 0) burst[i]--;
      end
      rst[1] = ($urandom_range(0, 2499) == 0);
      tick();
    end
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    rst[1] = 1'b0;
    wait_idle(0, 8000);
    wait_idle(1, 2000);
    repeat (5) tick();
    check("all_frames_seen0", exp_rd[0], exp_q[0].size());
    check("all_frames_seen1", exp_rd[1], exp_q[1].size());

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
